morse_key_decoder: RTL and testbench
====================================

# morse_key_decoder

Player-side stage of the Morse game. It samples the player's telegraph key once per time unit, using the same unit tick that drives the pattern shifter. It records the keyed pattern in the game's 13-bit LSB-first letter encoding and compares it with the target pattern from the letter lookup table. It then drives the win/lose indications and sits downstream of the letter selection / lookup stage.

## Interface
Parameters:
- GAP_UNITS, 3, consecutive key-up units that end a letter (legal 1..7)
- TIMEOUT_UNITS, 20, key-up units allowed before first press (legal 1..255; used only with MORSE_TIMEOUT_EN)

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- tick  input  1  one-cycle pulse per Morse unit (rate divider terminal count)
- arm  input  1  one-cycle pulse: latch target, start new attempt
- target  input  13  expected pattern, bit0 = leading off unit, 1 = key down
- key_n  input  1  raw player key, active-low, asynchronous
- captured  output  13  recorded pattern
- busy  output  1  attempt in progress (WAIT_KEY or CAPTURE)
- done  output  1  one-cycle pulse when the verdict is produced
- win  output  1  captured == latched target; held in DONE
- lose  output  1  mismatch or timeout; held in DONE

## Operation
- key_n passes through a 2-FF synchronizer and is inverted to key (1 = pressed). Only the synchronized value is used.
- Encoding rules:
  - bit0 is always 0.
  - bit k (k≥1) is the key level at the k-th tick, counting from the first pressed tick as k=1.
  - Unwritten bits are 0.
- States:
  - IDLE
    - busy=win=lose=0.
    - On arm: latch target, clear captured, idx=1, gap=0, go to WAIT_KEY.
  - WAIT_KEY
    - A tick with key=0 is ignored.
    - A tick with key=1 sets captured[1]=1, idx=2, gap=0, and goes to CAPTURE.
  - CAPTURE
    - Each tick: captured[idx]=key, idx=idx+1.
    - gap=0 if key=1, else gap=gap+1 (3-bit, saturating).
    - End when gap reaches GAP_UNITS, or when bit 12 has just been written.
    - On end: win = (captured_next == target_latched), lose = !win, done=1, go to DONE.
  - DONE
    - win/lose/captured are held.
    - arm restarts as from IDLE.
- arm has priority over tick in every state. arm while busy aborts the attempt and restarts it, clearing win/lose/captured.
- Between ticks the state, idx and gap do not change.
- The comparison is over all 13 bits. Trailing gap zeros match the target's zero padding.

## Timing
- Reset values: captured=0, busy=0, done=0, win=0, lose=0; state IDLE; idx=1; gap=0; timeout counter 0.
- Reset takes effect on the next clk edge and has priority over arm/tick. Reset during CAPTURE discards the partial pattern.
- Key-to-sample latency is 2 clk. A key edge must be stable for ≥2 clk before a tick to be seen at that tick.
- arm → busy=1 on the following cycle.
- The terminating tick is in cycle N. In cycle N+1: done=1 for exactly one cycle, win/lose are valid, and busy=0.
- captured updates in the cycle after each accepted tick.
- arm and tick in the same cycle: arm is taken and the tick is discarded.
- Maximum attempt length is 12 ticks after the first press. The 13-bit limit wins over the gap limit if both hit on the same tick. The verdict is the same either way.

## Configuration
- MORSE_TIMEOUT_EN defined:
  - WAIT_KEY counts ticks with key=0 in an 8-bit counter, cleared on arm.
  - On reaching TIMEOUT_UNITS: captured=0, lose=1, win=0, done pulse, go to DONE.
- MORSE_TIMEOUT_EN undefined:
  - No counter is present.
  - WAIT_KEY waits indefinitely; only arm or reset leaves it.

## Test plan
- Letter E: target=13'b0000000000010, arm. Key down at tick1, up at ticks 2-4. → after the 4th tick: captured=13'h0002, done pulse, win=1, lose=0.
- Letter A: target=13'b0000000111010. Key pattern down1/up1/down3/up3 → done after tick 8, captured=13'b0000000111010, win=1.
- Mismatch: target=A, key the E pattern → captured=13'h0002, win=0, lose=1, one-cycle done.
- Overflow: key held for 15 ticks → terminates at the 12th tick, captured=13'h1FFE, lose=1. Later ticks are ignored in DONE.
- Control corners:
  - Reset asserted mid-CAPTURE → next cycle all outputs 0, state IDLE.
  - arm and tick in the same cycle → no bit recorded, busy=1, captured=0.
  - arm during DONE → win/lose cleared, new attempt starts.
- Timeout, with MORSE_TIMEOUT_EN and TIMEOUT_UNITS=20: arm, then no key for 20 ticks → done, lose=1, captured=0. Without the macro, busy is still 1 after 100 ticks.

Source files
------------

// File: rtl/morse_key_decoder.sv
// Player-side Morse key decoder: captures keyed pattern per unit tick and judges it against the target.
// Optional build macro MORSE_TIMEOUT_EN adds a no-press timeout in WAIT_KEY.
module morse_key_decoder #(
    parameter int GAP_UNITS     = 3,
    parameter int TIMEOUT_UNITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        arm,
    input  logic [12:0] target,
    input  logic        key_n,
    output logic [12:0] captured,
    output logic        busy,
    output logic        done,
    output logic        win,
    output logic        lose
);

    // state    | meaning
    // IDLE     | no attempt, outputs cleared
    // WAIT_KEY | armed, waiting for the first pressed tick
    // CAPTURE  | recording one key level per tick
    // DONE     | verdict held until next arm
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [2:0] GAP_LIM = 3'(GAP_UNITS);

    if (GAP_UNITS < 1 || GAP_UNITS > 7) begin : g_bad_gap
        $error("GAP_UNITS out of range 1..7");
    end
    if (TIMEOUT_UNITS < 1 || TIMEOUT_UNITS > 255) begin : g_bad_timeout
        $error("TIMEOUT_UNITS out of range 1..255");
    end

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [2:0]  gap, gap_next;
    logic [12:0] target_q, target_next;
    logic [12:0] captured_next;
    logic        win_next, lose_next, done_next;
    logic        key_meta, key_sync;
    logic        key;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    assign key = ~key_sync;

`ifdef MORSE_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_UNITS);
    logic [7:0] tmo_cnt, tmo_next;

    always_ff @(posedge clk) begin
        if (reset) tmo_cnt <= 8'd0;
        else       tmo_cnt <= tmo_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 4'd1;
            gap      <= 3'd0;
            target_q <= 13'd0;
            captured <= 13'd0;
            win      <= 1'b0;
            lose     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            gap      <= gap_next;
            target_q <= target_next;
            captured <= captured_next;
            win      <= win_next;
            lose     <= lose_next;
            done     <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        gap_next      = gap;
        target_next   = target_q;
        captured_next = captured;
        win_next      = win;
        lose_next     = lose;
        done_next     = 1'b0;
`ifdef MORSE_TIMEOUT_EN
        tmo_next      = tmo_cnt;
`endif

        // arm outranks tick everywhere, so a coincident tick is simply dropped
        if (arm) begin
            state_next    = WAIT_KEY;
            idx_next      = 4'd1;
            gap_next      = 3'd0;
            target_next   = target;
            captured_next = 13'd0;
            win_next      = 1'b0;
            lose_next     = 1'b0;
`ifdef MORSE_TIMEOUT_EN
            tmo_next      = 8'd0;
`endif
        end else if (tick) begin
            case (state)
                WAIT_KEY: begin
                    if (key) begin
                        captured_next[1] = 1'b1;
                        idx_next         = 4'd2;
                        gap_next         = 3'd0;
                        state_next       = CAPTURE;
                    end else begin
`ifdef MORSE_TIMEOUT_EN
                        tmo_next = tmo_cnt + 8'd1;
                        if (tmo_next == TMO_LIM) begin
                            captured_next = 13'd0;
                            win_next      = 1'b0;
                            lose_next     = 1'b1;
                            done_next     = 1'b1;
                            state_next    = DONE;
                        end
`endif
                    end
                end
                CAPTURE: begin
                    captured_next[idx] = key;
                    idx_next           = idx + 4'd1;
                    if (key)             gap_next = 3'd0;
                    else if (gap != 3'd7) gap_next = gap + 3'd1;
                    // bit 12 is the last slot; running out of room ends the letter
                    if (idx == 4'd12 || gap_next == GAP_LIM) begin
                        win_next   = (captured_next == target_q);
                        lose_next  = (captured_next != target_q);
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == WAIT_KEY) || (state == CAPTURE);

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed self-checking bench for morse_key_decoder (default or MORSE_TIMEOUT_EN build).
module tb_morse_key_decoder;

    logic        clk = 1'b0;
    logic        reset, tick, arm, key_n;
    logic [12:0] target;
    logic [12:0] captured;
    logic        busy, done, win, lose;

    int checks   = 0;
    int failures = 0;

    localparam logic [12:0] PAT_E = 13'b0000000000010;
    localparam logic [12:0] PAT_A = 13'b0000000111010;

    morse_key_decoder #(.GAP_UNITS(3), .TIMEOUT_UNITS(20)) dut (
        .clk(clk), .reset(reset), .tick(tick), .arm(arm), .target(target),
        .key_n(key_n), .captured(captured), .busy(busy), .done(done),
        .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // key level is set, allowed to pass the synchronizer, then one tick is pulsed
    task automatic do_tick(input logic level);
        key_n = ~level;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_arm(input logic [12:0] t);
        target = t;
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; arm = 1'b0; key_n = 1'b1; target = 13'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_captured", captured, 13'd0);
        chk("rst_busy", 13'(busy), 13'd0);
        chk("rst_done", 13'(done), 13'd0);
        chk("rst_win", 13'(win), 13'd0);
        chk("rst_lose", 13'(lose), 13'd0);

        // letter E, matching
        do_arm(PAT_E);
        chk("e_busy_after_arm", 13'(busy), 13'd1);
        do_tick(1'b1);
        chk("e_capt_first", captured, 13'h0002);
        do_tick(1'b0);
        do_tick(1'b0);
        chk("e_done_early", 13'(done), 13'd0);
        do_tick(1'b0);
        chk("e_done", 13'(done), 13'd1);
        chk("e_win", 13'(win), 13'd1);
        chk("e_lose", 13'(lose), 13'd0);
        chk("e_captured", captured, 13'h0002);
        chk("e_busy_end", 13'(busy), 13'd0);
        @(negedge clk);
        chk("e_done_pulse", 13'(done), 13'd0);
        chk("e_win_held", 13'(win), 13'd1);

        // letter A, matching
        do_arm(PAT_A);
        do_tick(1'b1); do_tick(1'b0);
        do_tick(1'b1); do_tick(1'b1); do_tick(1'b1);
        do_tick(1'b0); do_tick(1'b0);
        chk("a_done_early", 13'(done), 13'd0);
        do_tick(1'b0);
        chk("a_done", 13'(done), 13'd1);
        chk("a_captured", captured, PAT_A);
        chk("a_win", 13'(win), 13'd1);

        // target A, keyed E
        do_arm(PAT_A);
        do_tick(1'b1); do_tick(1'b0); do_tick(1'b0); do_tick(1'b0);
        chk("mm_done", 13'(done), 13'd1);
        chk("mm_captured", captured, 13'h0002);
        chk("mm_win", 13'(win), 13'd0);
        chk("mm_lose", 13'(lose), 13'd1);
        @(negedge clk);
        chk("mm_done_pulse", 13'(done), 13'd0);
        chk("mm_lose_held", 13'(lose), 13'd1);

        // key held down: 12-tick limit
        do_arm(PAT_A);
        for (int i = 0; i < 11; i++) do_tick(1'b1);
        chk("ov_done_early", 13'(done), 13'd0);
        do_tick(1'b1);
        chk("ov_done", 13'(done), 13'd1);
        chk("ov_captured", captured, 13'h1FFE);
        chk("ov_lose", 13'(lose), 13'd1);
        for (int i = 0; i < 3; i++) do_tick(1'b1);
        chk("ov_captured_held", captured, 13'h1FFE);
        chk("ov_done_quiet", 13'(done), 13'd0);
        chk("ov_lose_held", 13'(lose), 13'd1);

        // arm in DONE clears verdict
        key_n = 1'b1;
        do_arm(PAT_E);
        chk("rearm_win", 13'(win), 13'd0);
        chk("rearm_lose", 13'(lose), 13'd0);
        chk("rearm_captured", captured, 13'd0);
        chk("rearm_busy", 13'(busy), 13'd1);

        // arm and tick together with key pressed: tick dropped
        key_n = 1'b0;
        repeat (2) @(negedge clk);
        arm = 1'b1; tick = 1'b1; target = PAT_E;
        @(negedge clk);
        arm = 1'b0; tick = 1'b0;
        chk("armtick_captured", captured, 13'd0);
        chk("armtick_busy", 13'(busy), 13'd1);
        do_tick(1'b1);
        chk("armtick_next", captured, 13'h0002);
        do_tick(1'b1);
        chk("mid_captured", captured, 13'h0006);

        // reset in the middle of CAPTURE
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_captured", captured, 13'd0);
        chk("mrst_busy", 13'(busy), 13'd0);
        chk("mrst_win", 13'(win), 13'd0);
        chk("mrst_lose", 13'(lose), 13'd0);
        do_tick(1'b1);
        chk("mrst_idle_tick", captured, 13'd0);
        chk("mrst_idle_busy", 13'(busy), 13'd0);

        // no press after arm
        do_arm(PAT_E);
`ifdef MORSE_TIMEOUT_EN
        for (int i = 0; i < 19; i++) do_tick(1'b0);
        chk("tmo_done_early", 13'(done), 13'd0);
        chk("tmo_busy_early", 13'(busy), 13'd1);
        do_tick(1'b0);
        chk("tmo_done", 13'(done), 13'd1);
        chk("tmo_lose", 13'(lose), 13'd1);
        chk("tmo_win", 13'(win), 13'd0);
        chk("tmo_captured", captured, 13'd0);
`else
        for (int i = 0; i < 100; i++) do_tick(1'b0);
        chk("wait_busy", 13'(busy), 13'd1);
        chk("wait_lose", 13'(lose), 13'd0);
        chk("wait_captured", captured, 13'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
